mem_port_arbiter: RTL and testbench

- Shares the single-ported Memory between two requesters: the instruction-fetch port (read-only) and the MEM-stage data port (read/write).
- Sequences each transaction over a fixed multi-cycle access window and returns one-cycle ready pulses; the pipeline stalls on not-ready.
- Sits between the IF/MEM stage logic and the Memory instance.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported Memory between the fetch port and the data port.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int N       = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_address,
    output logic         if_ready,
    output logic [N-1:0] if_rdata,
    input  logic         d_req,
    input  logic         d_write,
    input  logic [N-1:0] d_address,
    input  logic [N-1:0] d_wdata,
    output logic         d_ready,
    output logic [N-1:0] d_rdata,
    output logic [N-1:0] mem_address,
    output logic         mem_read_enable,
    output logic         mem_write_enable,
    output logic [N-1:0] mem_write_data,
    input  logic [N-1:0] mem_read_data,
    output logic         busy,
    output logic         owner
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mem_port_arbiter: LATENCY must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t       state_r, state_s;
    logic [3:0]   cnt_r, cnt_s;
    logic         grant_s, grant_data_s, capture_s, write_next_s;
    logic         owner_r, write_r;
    logic [N-1:0] addr_r, wdata_r, if_rdata_r, d_rdata_r;
    logic         rd_en_r, wr_en_r, if_ready_r, d_ready_r, busy_r;

    // Winner selection among the pending requests.
    always_comb begin
        grant_data_s = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (d_req && if_req) begin
            grant_data_s = ~owner_r;
        end else begin
            grant_data_s = d_req;
        end
`else
        grant_data_s = d_req;
`endif
    end

    // Next-state logic: IDLE grants, ACCESS counts down, DONE lasts one cycle.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        grant_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    grant_s = 1'b1;
                    state_s = ST_ACCESS;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    capture_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        if (grant_s) begin
            write_next_s = grant_data_s & d_write;
        end else begin
            write_next_s = write_r;
        end
    end

    // State, latched transaction and registered outputs; reset clears everything at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            owner_r    <= 1'b0;
            write_r    <= 1'b0;
            addr_r     <= {N{1'b0}};
            wdata_r    <= {N{1'b0}};
            if_rdata_r <= {N{1'b0}};
            d_rdata_r  <= {N{1'b0}};
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            if_ready_r <= 1'b0;
            d_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (grant_s) begin
                owner_r <= grant_data_s;
                write_r <= write_next_s;
                addr_r  <= grant_data_s ? d_address : if_address;
                wdata_r <= grant_data_s ? d_wdata : {N{1'b0}};
            end
            // Stores never overwrite d_rdata; only loads and fetches capture.
            if (capture_s && !write_r) begin
                if (owner_r) begin
                    d_rdata_r <= mem_read_data;
                end else begin
                    if_rdata_r <= mem_read_data;
                end
            end
            rd_en_r    <= (state_s == ST_ACCESS) && !write_next_s;
            wr_en_r    <= (state_s == ST_ACCESS) && write_next_s;
            if_ready_r <= capture_s && !owner_r;
            d_ready_r  <= capture_s && owner_r;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign if_ready         = if_ready_r;
    assign if_rdata         = if_rdata_r;
    assign d_ready          = d_ready_r;
    assign d_rdata          = d_rdata_r;
    assign mem_address      = addr_r;
    assign mem_read_enable  = rd_en_r;
    assign mem_write_enable = wr_en_r;
    assign mem_write_data   = wdata_r;
    assign busy             = busy_r;
    assign owner            = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-timeline model plus directed vectors.
// Define MEM_ARB_RR_EN to exercise the round-robin build.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_address = 32'h0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_address;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        owner;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.LATENCY(LAT), .N(32)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_address(if_address), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] default_word(input logic [7:0] a);
        return {24'hA5C300, a};
    endfunction

    // Bench-side Memory: combinational read, write on posedge.
    logic [31:0] mem_store [0:255];
    assign mem_read_data = mem_read_enable ? mem_store[mem_address[7:0]] : 32'h0;

    initial begin
        for (int i = 0; i < 256; i++) mem_store[i] = default_word(8'(i));
        mem_store[8] = 32'h8C020004;
        forever begin
            @(posedge clock);
            if (mem_write_enable) mem_store[mem_address[7:0]] = mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, described by its phase since grant.
    logic [31:0] ref_mem [0:255];
    bit          m_active;
    int          m_ph;
    bit          m_owner, m_write;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

    task automatic m_reset();
        m_active = 1'b0; m_ph = 0; m_owner = 1'b0; m_write = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_if_rdata = 32'h0; m_d_rdata = 32'h0;
    endtask

    initial begin
        bit pick_d;
        for (int i = 0; i < 256; i++) ref_mem[i] = default_word(8'(i));
        ref_mem[8] = 32'h8C020004;
        m_reset();
        forever begin
            @(posedge clock);
            if (!reset) begin
                m_reset();
            end else if (m_active) begin
                m_ph++;
                if (m_ph == LAT) begin
                    if (m_write) ref_mem[m_addr[7:0]] = m_wdata;
                    else if (m_owner) m_d_rdata = ref_mem[m_addr[7:0]];
                    else m_if_rdata = ref_mem[m_addr[7:0]];
                end else if (m_ph == LAT + 1) begin
                    m_active = 1'b0;
                end
            end else if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
                pick_d = (if_req && d_req) ? !m_owner : d_req;
`else
                pick_d = d_req;
`endif
                m_active = 1'b1; m_ph = 0; m_owner = pick_d;
                m_write  = pick_d && d_write;
                m_addr   = pick_d ? d_address : if_address;
                m_wdata  = pick_d ? d_wdata : 32'h0;
            end
            @(negedge clock);
            if (!reset) m_reset();
            check("mem_read_enable", 32'(mem_read_enable), 32'(m_active && m_ph < LAT && !m_write));
            check("mem_write_enable", 32'(mem_write_enable), 32'(m_active && m_ph < LAT && m_write));
            check("mem_address", mem_address, m_addr);
            if (m_active && m_ph < LAT && m_write) check("mem_write_data", mem_write_data, m_wdata);
            check("if_ready", 32'(if_ready), 32'(m_active && m_ph == LAT && !m_owner));
            check("d_ready", 32'(d_ready), 32'(m_active && m_ph == LAT && m_owner));
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            check("busy", 32'(busy), 32'(m_active));
            check("owner", 32'(owner), 32'(m_owner));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Waits (bounded) for a ready pulse on the chosen port; n counts negedges waited.
    task automatic wait_ready(input bit port_d, output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 1; i <= 30 && !found; i++) begin
            @(negedge clock);
            if (port_d ? d_ready : if_ready) begin
                found = 1'b1;
                n = i;
            end
        end
        check("ready_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("post_reset_owner", 32'(owner), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Lone fetch of word 8.
        if_req = 1'b1; if_address = 32'h8;
        wait_ready(1'b0, n);
        check("fetch_latency", 32'(n), 32'(LAT + 1));
        if_req = 1'b0;
        tick(2);
        check("fetch_rdata_held", if_rdata, 32'h8C020004);

        // Store then load on 0x20.
        d_req = 1'b1; d_write = 1'b1; d_address = 32'h20; d_wdata = 32'hDEADBEEF;
        wait_ready(1'b1, n);
        d_req = 1'b0; d_write = 1'b0;
        tick(1);
        d_req = 1'b1;
        wait_ready(1'b1, n);
        d_req = 1'b0;
        tick(1);
        check("load_after_store", d_rdata, 32'hDEADBEEF);

`ifdef MEM_ARB_RR_EN
        // Round-robin from reset owner 0 with both requests held.
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        if_req = 1'b1; if_address = 32'h8; d_req = 1'b1; d_address = 32'h20;
        for (int k = 0; k < 4; k++) begin
            bit found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clock);
                if (if_ready || d_ready) found = 1'b1;
            end
            check("rr_timeout", 32'(found), 32'd1);
            check("rr_owner", 32'(owner), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(2);
`else
        // Simultaneous requests: data first, fetch LAT+2 cycles later.
        if_req = 1'b1; if_address = 32'h8; d_req = 1'b1; d_address = 32'h20;
        wait_ready(1'b1, n);
        check("simul_data_first_owner", 32'(owner), 32'd1);
        d_req = 1'b0;
        wait_ready(1'b0, n);
        check("simul_fetch_gap", 32'(n), 32'(LAT + 2));
        if_req = 1'b0;
        tick(2);
`endif

        // Protocol violation: request dropped and address changed mid-access.
        if_req = 1'b1; if_address = 32'h4;
        tick(1);
        if_req = 1'b0; if_address = 32'h44;
        check("violation_addr_held", mem_address, 32'h4);
        wait_ready(1'b0, n);
        check("violation_ready", 32'(n), 32'(LAT));
        tick(4);
        check("violation_no_retry", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a store.
        d_req = 1'b1; d_write = 1'b1; d_address = 32'h10; d_wdata = 32'h12345678;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_wr_en", 32'(mem_write_enable), 32'd0);
        check("rst_rd_en", 32'(mem_read_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_write = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("rst_idle_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
